// File: rtl/icache_tag_ctrl_pkg.sv
// Shared widths, cache-op encodings and controller state encoding for the
// instruction-cache tag controller.
package icache_tag_ctrl_pkg;

  localparam int TAG_W   = 20;
  localparam int IDX_W   = 7;
  localparam int ENTRY_W = 21;

  typedef enum logic [1:0] {
    CACOP_IDX_INV = 2'b00,
    CACOP_HIT_INV = 2'b01,
    CACOP_RSVD0   = 2'b10,
    CACOP_RSVD1   = 2'b11
  } cacop_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIT_RD  = 2'd1,
    ST_HIT_CMP = 2'd2,
    ST_HIT_WR  = 2'd3
  } state_e;

  // A freshly installed tag is always valid.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [TAG_W-1:0] tag);
    return {1'b1, tag};
  endfunction

endpackage

// File: rtl/icache_tag_ctrl_if.sv
// Request/ack and tag-RAM signals of the tag controller; the controller
// takes the slave view, the requesters and RAM side take the master view.
interface icache_tag_ctrl_if;
  import icache_tag_ctrl_pkg::*;

  logic [IDX_W-1:0]   fetch_index1;
  logic [IDX_W-1:0]   fetch_index2;

  logic               refill_req1;
  logic               refill_req2;
  logic [IDX_W-1:0]   refill_index1;
  logic [IDX_W-1:0]   refill_index2;
  logic [TAG_W-1:0]   refill_tag1;
  logic [TAG_W-1:0]   refill_tag2;
  logic               refill_ack1;
  logic               refill_ack2;

  logic               cacop_req;
  logic [1:0]         cacop_op;
  logic [IDX_W-1:0]   cacop_idx;
  logic [TAG_W-1:0]   cacop_tag;
  logic               cacop_ack;
  logic               cacop_done;

  logic               fetch_stall;
  logic               busy;

  logic               ram_we1;
  logic               ram_we2;
  logic               ram_flush;
  logic [IDX_W-1:0]   ram_index1;
  logic [IDX_W-1:0]   ram_index2;
  logic [IDX_W-1:0]   ram_cacop_index;
  logic [ENTRY_W-1:0] ram_data_in;
  logic [ENTRY_W-1:0] ram_out1;
  logic [ENTRY_W-1:0] ram_out2;

  modport master (
    output fetch_index1, fetch_index2,
    output refill_req1, refill_req2, refill_index1, refill_index2,
    output refill_tag1, refill_tag2,
    input  refill_ack1, refill_ack2,
    output cacop_req, cacop_op, cacop_idx, cacop_tag,
    input  cacop_ack, cacop_done,
    input  fetch_stall, busy,
    input  ram_we1, ram_we2, ram_flush,
    input  ram_index1, ram_index2, ram_cacop_index, ram_data_in,
    output ram_out1, ram_out2
  );

  modport slave (
    input  fetch_index1, fetch_index2,
    input  refill_req1, refill_req2, refill_index1, refill_index2,
    input  refill_tag1, refill_tag2,
    output refill_ack1, refill_ack2,
    input  cacop_req, cacop_op, cacop_idx, cacop_tag,
    output cacop_ack, cacop_done,
    output fetch_stall, busy,
    output ram_we1, ram_we2, ram_flush,
    output ram_index1, ram_index2, ram_cacop_index, ram_data_in,
    input  ram_out1, ram_out2
  );

endinterface

// File: rtl/icache_tag_ctrl.sv
// Tag-RAM controller: arbitrates two refill lanes and a cache-op port, and
// sequences hit-invalidate as read / compare / flush on lookup port 1.
module icache_tag_ctrl
  import icache_tag_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  icache_tag_ctrl_if.slave bus
);

  state_e           state;
  state_e           state_next;
  cacop_op_e        op_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept_q;
  logic             accept;
  logic             tag_hit;
  logic             unused_ram_out2;

  assign tag_hit  = bus.ram_out1[ENTRY_W-1] && (bus.ram_out1[TAG_W-1:0] == tag_q);
  assign bus.busy = (state != ST_IDLE);

  // Lane-2 read data belongs to the fetch path and is never inspected here.
  assign unused_ram_out2 = ^bus.ram_out2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= CACOP_IDX_INV;
      idx_q    <= '0;
      tag_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      state    <= state_next;
      accept_q <= accept;
      if (accept) begin
        op_q  <= cacop_op_e'(bus.cacop_op);
        idx_q <= bus.cacop_idx;
        tag_q <= bus.cacop_tag;
      end
    end
  end

  // accept_q marks the cycle after an accept; single-cycle ops complete
  // there, and a new op is refused there so completions never overlap.
  always_comb begin
    state_next          = state;
    accept              = 1'b0;
    bus.ram_we1         = 1'b0;
    bus.ram_we2         = 1'b0;
    bus.ram_flush       = 1'b0;
    bus.ram_index1      = bus.fetch_index1;
    bus.ram_index2      = bus.fetch_index2;
    bus.ram_cacop_index = idx_q;
    bus.ram_data_in     = '0;
    bus.refill_ack1     = 1'b0;
    bus.refill_ack2     = 1'b0;
    bus.cacop_ack       = 1'b0;
    bus.cacop_done      = 1'b0;
    bus.fetch_stall     = 1'b0;

    if (!rst) begin
      case (state)
        ST_IDLE: begin
          bus.cacop_done = accept_q && (op_q != CACOP_HIT_INV);
          if (bus.refill_req1) begin
            bus.ram_we1     = 1'b1;
            bus.ram_index1  = bus.refill_index1;
            bus.ram_data_in = make_entry(bus.refill_tag1);
            bus.refill_ack1 = 1'b1;
          end else if (bus.refill_req2) begin
            bus.ram_we2     = 1'b1;
            bus.ram_index2  = bus.refill_index2;
            bus.ram_data_in = make_entry(bus.refill_tag2);
            bus.refill_ack2 = 1'b1;
          end else if (bus.cacop_req && !accept_q) begin
            accept        = 1'b1;
            bus.cacop_ack = 1'b1;
            if (cacop_op_e'(bus.cacop_op) == CACOP_HIT_INV) begin
              state_next = ST_HIT_RD;
            end else if (cacop_op_e'(bus.cacop_op) == CACOP_IDX_INV) begin
              bus.ram_flush       = 1'b1;
              bus.ram_cacop_index = bus.cacop_idx;
            end
          end
        end

        ST_HIT_RD: begin
          bus.ram_index1  = idx_q;
          bus.fetch_stall = 1'b1;
          state_next      = ST_HIT_CMP;
        end

        ST_HIT_CMP: begin
          if (tag_hit) begin
            state_next = ST_HIT_WR;
          end else begin
            bus.cacop_done = 1'b1;
            state_next     = ST_IDLE;
          end
        end

        ST_HIT_WR: begin
          bus.ram_flush       = 1'b1;
          bus.ram_cacop_index = idx_q;
          bus.cacop_done      = 1'b1;
          state_next          = ST_IDLE;
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: directed cycle table, then randomized traffic
// against a transaction-level model, with a behavioural tag RAM attached.
module tb_icache_tag_ctrl;
  import icache_tag_ctrl_pkg::*;

  typedef struct packed {
    logic        rst;
    logic [6:0]  fi1;
    logic [6:0]  fi2;
    logic        rq1;
    logic [6:0]  ri1;
    logic [19:0] rt1;
    logic        rq2;
    logic [6:0]  ri2;
    logic [19:0] rt2;
    logic        cq;
    logic [1:0]  cop;
    logic [6:0]  ci;
    logic [19:0] ct;
  } stim_t;

  typedef struct packed {
    logic        we1;
    logic        we2;
    logic        flush;
    logic [6:0]  index1;
    logic [6:0]  index2;
    logic [6:0]  cindex;
    logic [20:0] data;
    logic        ack1;
    logic        ack2;
    logic        cack;
    logic        done;
    logic        stall;
    logic        busy;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_tag_ctrl_if bus ();

  icache_tag_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [20:0] ram_mem   [128];
  logic [20:0] model_mem [128];
  int checks = 0;
  int errors = 0;

  int          m_age;
  logic        m_pend;
  logic        m_hit;
  logic [6:0]  m_idx;
  logic [19:0] m_tag;

  // Drive one cycle of stimulus, sample outputs mid-cycle, then play the
  // registered tag RAM (read-before-write) on the following edge.
  task automatic apply_stimulus(input stim_t s, output obs_t got);
    logic [20:0] r1, r2;
    @(negedge clk);
    rst               = s.rst;
    bus.fetch_index1  = s.fi1;
    bus.fetch_index2  = s.fi2;
    bus.refill_req1   = s.rq1;
    bus.refill_index1 = s.ri1;
    bus.refill_tag1   = s.rt1;
    bus.refill_req2   = s.rq2;
    bus.refill_index2 = s.ri2;
    bus.refill_tag2   = s.rt2;
    bus.cacop_req     = s.cq;
    bus.cacop_op      = s.cop;
    bus.cacop_idx     = s.ci;
    bus.cacop_tag     = s.ct;
    #1;
    got.we1    = bus.ram_we1;
    got.we2    = bus.ram_we2;
    got.flush  = bus.ram_flush;
    got.index1 = bus.ram_index1;
    got.index2 = bus.ram_index2;
    got.cindex = bus.ram_cacop_index;
    got.data   = bus.ram_data_in;
    got.ack1   = bus.refill_ack1;
    got.ack2   = bus.refill_ack2;
    got.cack   = bus.cacop_ack;
    got.done   = bus.cacop_done;
    got.stall  = bus.fetch_stall;
    got.busy   = bus.busy;
    @(posedge clk);
    #1;
    r1 = ram_mem[got.index1];
    r2 = ram_mem[got.index2];
    if (got.we1 === 1'b1) ram_mem[got.index1] = got.data;
    if (got.we2 === 1'b1) ram_mem[got.index2] = got.data;
    if (got.flush === 1'b1) ram_mem[got.cindex] = '0;
    bus.ram_out1 = r1;
    bus.ram_out2 = r2;
  endtask

  // Flush index and write data only matter when their enables are expected.
  function automatic obs_t masked(input obs_t o, input obs_t want);
    obs_t m;
    m = o;
    if (!want.flush) m.cindex = '0;
    if (!(want.we1 || want.we2)) m.data = '0;
    return m;
  endfunction

  task automatic check_output(input string name, input obs_t got, input obs_t want);
    obs_t g, w;
    g = masked(got, want);
    w = masked(want, want);
    checks++;
    if (g !== w) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, g, w);
    end
  endtask

  function automatic stim_t st(input logic r,
                               input logic q1, input logic [6:0] i1, input logic [19:0] t1,
                               input logic q2, input logic [6:0] i2, input logic [19:0] t2,
                               input logic cq, input logic [1:0] op, input logic [6:0] ci,
                               input logic [19:0] ct);
    stim_t s;
    s.rst = r;  s.fi1 = 7'h11; s.fi2 = 7'h22;
    s.rq1 = q1; s.ri1 = i1; s.rt1 = t1;
    s.rq2 = q2; s.ri2 = i2; s.rt2 = t2;
    s.cq  = cq; s.cop = op; s.ci = ci; s.ct = ct;
    return s;
  endfunction

  function automatic obs_t ex(input logic w1, input logic w2, input logic fl,
                              input logic [6:0] i1, input logic [6:0] i2, input logic [6:0] ci,
                              input logic [20:0] d, input logic a1, input logic a2,
                              input logic ca, input logic dn, input logic sl, input logic bz);
    obs_t e;
    e.we1 = w1; e.we2 = w2; e.flush = fl;
    e.index1 = i1; e.index2 = i2; e.cindex = ci; e.data = d;
    e.ack1 = a1; e.ack2 = a2; e.cack = ca; e.done = dn; e.stall = sl; e.busy = bz;
    return e;
  endfunction

  // Model: m_age counts cycles since a hit-invalidate was accepted (0 = none);
  // m_pend means a single-cycle op was accepted last cycle.
  function automatic obs_t model_predict(input stim_t s);
    obs_t w;
    w        = '0;
    w.index1 = s.fi1;
    w.index2 = s.fi2;
    w.busy   = (m_age != 0);
    if (s.rst) return w;
    if (m_age == 1) begin
      w.stall  = 1'b1;
      w.index1 = m_idx;
    end else if (m_age == 2) begin
      w.done = !m_hit;
    end else if (m_age == 3) begin
      w.flush  = 1'b1;
      w.cindex = m_idx;
      w.done   = 1'b1;
    end else begin
      w.done = m_pend;
      if (s.rq1) begin
        w.we1 = 1'b1; w.index1 = s.ri1; w.data = {1'b1, s.rt1}; w.ack1 = 1'b1;
      end else if (s.rq2) begin
        w.we2 = 1'b1; w.index2 = s.ri2; w.data = {1'b1, s.rt2}; w.ack2 = 1'b1;
      end else if (s.cq && !m_pend) begin
        w.cack = 1'b1;
        if (s.cop == 2'b00) begin
          w.flush  = 1'b1;
          w.cindex = s.ci;
        end
      end
    end
    return w;
  endfunction

  task automatic model_update(input stim_t s, input obs_t w);
    if (s.rst) begin
      m_age  = 0;
      m_pend = 1'b0;
      return;
    end
    if (w.we1) model_mem[w.index1] = w.data;
    if (w.we2) model_mem[w.index2] = w.data;
    if (w.flush) model_mem[w.cindex] = '0;
    m_pend = w.cack && (s.cop != 2'b01);
    if (w.cack && s.cop == 2'b01) begin
      m_age = 1;
      m_idx = s.ci;
      m_tag = s.ct;
    end else if (m_age == 1) begin
      m_age = 2;
      m_hit = (model_mem[m_idx] == {1'b1, m_tag});
    end else if (m_age == 2) begin
      m_age = m_hit ? 3 : 0;
    end else begin
      m_age = 0;
    end
  endtask

  initial begin
    vec_t  dir[$];
    stim_t s;
    stim_t n;
    obs_t  got;
    obs_t  want;
    obs_t  e0;
    logic        p1, p2, pc;
    logic [6:0]  i1, i2, ci;
    logic [19:0] t1, t2, ct;
    logic [1:0]  cop;

    bus.ram_out1 = '0;
    bus.ram_out2 = '0;
    for (int i = 0; i < 128; i++) ram_mem[i] = '0;
    ram_mem[3] = 21'h100042;
    ram_mem[4] = 21'h000042;
    ram_mem[6] = 21'h100042;
    ram_mem[7] = 21'h100099;

    n  = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e0 = ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 0, 0, 0);

    dir.push_back('{st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), e0});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 1, 7'd5, 20'h12345, 1, 7'd9, 20'hABCDE, 0, 0, 0, 0),
                    ex(1, 0, 0, 7'd5, 7'h22, 0, 21'h112345, 1, 0, 0, 0, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 1, 7'd9, 20'hABCDE, 0, 0, 0, 0),
                    ex(0, 1, 0, 7'h11, 7'd9, 0, 21'h1ABCDE, 0, 1, 0, 0, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 7'h7F, 0),
                    ex(0, 0, 1, 7'h11, 7'h22, 7'h7F, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 0)});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 7'd3, 20'h00042),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'd3, 7'h22, 0, 0, 0, 0, 0, 0, 1, 1)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 0, 0, 1)});
    dir.push_back('{n, ex(0, 0, 1, 7'h11, 7'h22, 7'd3, 0, 0, 0, 0, 1, 0, 1)});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 7'd6, 20'h00043),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'd6, 7'h22, 0, 0, 0, 0, 0, 0, 1, 1)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 1)});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 7'd4, 20'h00042),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'd4, 7'h22, 0, 0, 0, 0, 0, 0, 1, 1)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 1)});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 7'd6, 20'h00042),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{st(0, 1, 7'h10, 20'h55555, 0, 0, 0, 0, 0, 0, 0),
                    ex(0, 0, 0, 7'd6, 7'h22, 0, 0, 0, 0, 0, 0, 1, 1)});
    dir.push_back('{st(0, 1, 7'h10, 20'h55555, 0, 0, 0, 0, 0, 0, 0),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 0, 0, 1)});
    dir.push_back('{st(0, 1, 7'h10, 20'h55555, 0, 0, 0, 0, 0, 0, 0),
                    ex(0, 0, 1, 7'h11, 7'h22, 7'd6, 0, 0, 0, 0, 1, 0, 1)});
    dir.push_back('{st(0, 1, 7'h10, 20'h55555, 0, 0, 0, 0, 0, 0, 0),
                    ex(1, 0, 0, 7'h10, 7'h22, 0, 21'h155555, 1, 0, 0, 0, 0, 0)});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 7'd7, 20'h00099),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'd7, 7'h22, 0, 0, 0, 0, 0, 0, 1, 1)});
    dir.push_back('{st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 0, 0, 1)});
    dir.push_back('{n, e0});
    dir.push_back('{n, e0});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 7'd5, 0),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 7'd5, 0),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 7'd5, 0),
                    ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 1, 7'd2, 20'h00001, 1, 2'b00, 7'd1, 0),
                    ex(0, 1, 0, 7'h11, 7'd2, 0, 21'h100001, 0, 1, 0, 0, 0, 0)});
    dir.push_back('{st(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 7'd1, 0),
                    ex(0, 0, 1, 7'h11, 7'h22, 7'd1, 0, 0, 0, 1, 0, 0, 0)});
    dir.push_back('{n, ex(0, 0, 0, 7'h11, 7'h22, 0, 0, 0, 0, 0, 1, 0, 0)});
    dir.push_back('{st(1, 1, 7'h30, 20'h00007, 0, 0, 0, 0, 0, 0, 0), e0});
    dir.push_back('{n, e0});

    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), got);
    apply_stimulus(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), got);

    for (int i = 0; i < dir.size(); i++) begin
      apply_stimulus(dir[i].s, got);
      check_output($sformatf("directed %0d", i), got, dir[i].e);
    end

    // Random phase: sets 0..7 preloaded from a small tag pool so hits occur.
    for (int i = 0; i < 128; i++) begin
      ram_mem[i]   = (i < 8) ? {1'b1, 20'(20'h40 + i % 3)} : 21'h0;
      model_mem[i] = ram_mem[i];
    end
    m_age = 0; m_pend = 1'b0; m_hit = 1'b0; m_idx = '0; m_tag = '0;
    p1 = 0; p2 = 0; pc = 0;
    i1 = 0; i2 = 0; ci = 0; t1 = 0; t2 = 0; ct = 0; cop = 0;

    for (int c = 0; c < 600; c++) begin
      if (!p1 && $urandom_range(0, 3) == 0) begin
        p1 = 1; i1 = 7'($urandom_range(0, 7)); t1 = 20'(20'h40 + $urandom_range(0, 2));
      end
      if (!p2 && $urandom_range(0, 3) == 0) begin
        p2 = 1; i2 = 7'($urandom_range(0, 7)); t2 = 20'(20'h40 + $urandom_range(0, 2));
      end
      if (!pc && $urandom_range(0, 2) == 0) begin
        pc  = 1;
        cop = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
        ci  = 7'($urandom_range(0, 7));
        ct  = 20'(20'h40 + $urandom_range(0, 2));
      end
      s.rst = ($urandom_range(0, 49) == 0);
      s.fi1 = 7'($urandom); s.fi2 = 7'($urandom);
      s.rq1 = p1; s.ri1 = i1; s.rt1 = t1;
      s.rq2 = p2; s.ri2 = i2; s.rt2 = t2;
      s.cq  = pc; s.cop = cop; s.ci = ci; s.ct = ct;
      want = model_predict(s);
      apply_stimulus(s, got);
      check_output($sformatf("random %0d", c), got, want);
      model_update(s, want);
      if (got.ack1 === 1'b1) p1 = 0;
      if (got.ack2 === 1'b1) p2 = 0;
      if (got.cack === 1'b1) pc = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
